// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               fetch FSM state encoding, buffer entry layout, default
//               reset PC and the base opcode constants seen by decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch FSM states: REQ may issue, WAIT has one request in flight,
    // DROP swallows the response of a request made stale by a redirect.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // One buffered instruction: the fetched word and the address it came from.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Small instruction FIFO between the fetch FSM and decode.
//               Push and pop in the same cycle keep occupancy unchanged;
//               flush empties the buffer and wins over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t pushData,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t headData,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               w_doPush;
    logic               w_doPop;

    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_doPop  = pop & ~empty;
    // A push into a full buffer is accepted only when the head leaves this cycle.
    assign w_doPush = push & (~full | w_doPop);
    assign headData = r_mem[r_rdPtr];

    // Storage: cleared on reset so the head reads as all zeros afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doPush && !flush) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy; flush discards everything in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Issues one word-aligned request at a
//               time to instruction memory, buffers returned words in a
//               2-entry FIFO toward decode, and restarts on redirect while
//               discarding any response made stale by it.
//               Optional feature macro IFETCH_PERF_CNT_EN adds output
//               perf_fetched, a free-running count of instructions popped
//               by decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched
`endif
);

    fetch_state_e r_state;
    fetch_state_e w_nextState;
    logic [31:0]  r_fetchPc;
    logic [31:0]  r_reqPc;
    logic         w_grant;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_pushData;
    fetch_entry_t w_head;
    logic         w_unusedRedirLow;

    // Redirect targets are forced to word alignment; the low bits are ignored.
    assign w_unusedRedirLow = ^redirect_pc[1:0];

    assign w_grant = imem_req & imem_gnt;
    // Redirect outranks any push or pop happening in the same cycle.
    assign w_push  = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;
    assign w_pop   = instr_valid & instr_ready & ~redirect_valid;

    assign w_pushData.word = imem_rdata;
    assign w_pushData.pc   = r_reqPc;

    fetch_buf #(
        .DEPTH    (BUF_DEPTH)
    ) u_fetchBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .pushData (w_pushData),
        .pop      (w_pop),
        .flush    (redirect_valid),
        .headData (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign instr_valid = ~w_empty;
    assign instr       = w_head.word;
    assign instr_pc    = w_head.pc;
    assign opcode      = w_head.word[6:0];
    assign imem_addr   = r_fetchPc;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    // A request granted alongside the redirect will still answer.
                    w_nextState = w_grant ? S_DROP : S_REQ;
                end else if (w_grant) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    // If the stale response lands in the redirect cycle it is
                    // already discarded, so there is nothing left to drop.
                    w_nextState = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_nextState = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_nextState = S_REQ;
                end
            end
            default: begin
                w_nextState = S_REQ;
            end
        endcase
    end

    // FSM outputs: request only in REQ with buffer space, never during reset.
    always_comb begin
        imem_req = rst_n & (r_state == S_REQ) & ~w_full;
    end

    // Fetch address: redirect restarts it, a grant advances it by one word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchPc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetchPc <= {redirect_pc[31:2], 2'b00};
        end else if (w_grant) begin
            r_fetchPc <= r_fetchPc + 32'd4;
        end
    end

    // Address of the outstanding request, tagged onto its returning word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reqPc <= '0;
        end else if (w_grant && !redirect_valid) begin
            r_reqPc <= r_fetchPc;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perfFetched;

    // Count instructions handed to decode; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perfFetched <= '0;
        end else if (w_pop) begin
            r_perfFetched <= r_perfFetched + 32'd1;
        end
    end

    assign perf_fetched = r_perfFetched;
`endif

endmodule
`default_nettype wire
